// File: rtl/mem_stage_pkg.sv
// Shared types and default sizing for the memory-stage access engine.
package mem_stage_pkg;

  localparam int unsigned MS_N   = 24;
  localparam int unsigned MS_VW  = 256;
  localparam int unsigned MS_MW  = 32;
  localparam int unsigned BEATS  = MS_VW / MS_MW;
  localparam int unsigned CNT_W  = $clog2(BEATS) + 1;
  localparam int unsigned LANE_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    VWR,
    VRD,
    DONE
  } ms_state_t;

endpackage

// File: rtl/memory_stage_unit_vec_beat_assembler.sv
// Collects MW-bit read beats into a VW-bit vector, one lane per enabled cycle.
module vec_beat_assembler
  import mem_stage_pkg::*;
#(
  parameter int unsigned VW = MS_VW,
  parameter int unsigned MW = MS_MW,
  parameter int unsigned LW = LANE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [LW-1:0] lane,
  input  logic [MW-1:0] rdata,
  output logic [VW-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (en) begin
      data[MW*int'(lane) +: MW] <= rdata;
    end
  end

endmodule

// File: rtl/memory_stage_unit.sv
// Memory-stage access engine: single-cycle scalar accesses, vector accesses
// serialised into MW-bit beats while the upstream pipeline is stalled.
module memory_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int unsigned N  = MS_N,
  parameter int unsigned VW = MS_VW,
  parameter int unsigned MW = MS_MW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemWriteM,
  input  logic          MemtoRegM,
  input  logic          VecOpM,
  input  logic [N-1:0]  ALUResultM,
  input  logic [N-1:0]  WriteDataM,
  input  logic [VW-1:0] vWriteDataM,
  output logic [N-1:0]  mem_addr,
  output logic [MW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [MW-1:0] mem_rdata,
  output logic [N-1:0]  ReadDataM,
  output logic [VW-1:0] vReadDataM,
  output logic          StallM,
  output logic          vDoneM
);

  localparam int unsigned NBEATS = VW / MW;
  localparam int unsigned CW     = $clog2(NBEATS) + 1;
  localparam int unsigned LW     = $clog2(NBEATS);

  typedef struct packed {
    logic [N-1:0]  base;
    logic [VW-1:0] vdata;
  } vec_req_t;

  ms_state_t     state, state_nx;
  logic [CW-1:0] beat, beat_nx;
  vec_req_t      req;
  logic          accept;
  logic          cap_en;
  logic [LW-1:0] cap_lane;

  assign accept = (state == IDLE) && VecOpM && (MemWriteM || MemtoRegM);

  // State, beat counter and the vector request captured at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      req   <= '0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
      if (accept) begin
        req.base  <= ALUResultM;
        req.vdata <= vWriteDataM;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    beat_nx   = beat;
    mem_addr  = req.base + N'(beat);
    mem_wdata = '0;
    mem_we    = 1'b0;
    StallM    = 1'b0;
    cap_en    = 1'b0;
    cap_lane  = LW'(beat - CW'(1));

    case (state)
      IDLE: begin
        mem_addr  = ALUResultM;
        mem_wdata = MW'(WriteDataM);
        mem_we    = MemWriteM && !VecOpM;
        if (accept) begin
          StallM   = 1'b1;
          beat_nx  = '0;
          // A request with both store and load set is handled as a store
          state_nx = MemWriteM ? VWR : VRD;
        end
      end
      VWR: begin
        StallM    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = req.vdata[MW*int'(beat[LW-1:0]) +: MW];
        if (beat == CW'(NBEATS - 1)) begin
          beat_nx  = '0;
          state_nx = DONE;
        end else begin
          beat_nx = beat + CW'(1);
        end
      end
      VRD: begin
        // Read data trails the address by one cycle; the final count is the drain cycle
        StallM = 1'b1;
        cap_en = (beat != '0);
        if (beat == CW'(NBEATS)) begin
          beat_nx  = '0;
          state_nx = DONE;
        end else begin
          beat_nx = beat + CW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Reset aborts the operation in the cycle it is seen
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  assign vDoneM    = (state == DONE);
  assign ReadDataM = mem_rdata[N-1:0];

  vec_beat_assembler #(
    .VW(VW),
    .MW(MW),
    .LW(LW)
  ) u_assembler (
    .clk  (clk),
    .rst  (rst),
    .en   (cap_en),
    .lane (cap_lane),
    .rdata(mem_rdata),
    .data (vReadDataM)
  );

endmodule

// File: tb/tb_memory_stage_unit.sv
// Scoreboard bench for memory_stage_unit with a word-addressed memory model.
module tb_memory_stage_unit;

  localparam int unsigned N  = 24;
  localparam int unsigned VW = 256;
  localparam int unsigned MW = 32;
  localparam int unsigned NB = VW / MW;

  localparam int K_WR = 0;
  localparam int K_RD = 1;
  localparam int K_VD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          MemWriteM, MemtoRegM, VecOpM;
  logic [N-1:0]  ALUResultM, WriteDataM;
  logic [VW-1:0] vWriteDataM;
  logic [N-1:0]  mem_addr;
  logic [MW-1:0] mem_wdata;
  logic          mem_we;
  logic [MW-1:0] mem_rdata;
  logic [N-1:0]  ReadDataM;
  logic [VW-1:0] vReadDataM;
  logic          StallM, vDoneM;

  memory_stage_unit dut (
    .clk        (clk),
    .rst        (rst),
    .MemWriteM  (MemWriteM),
    .MemtoRegM  (MemtoRegM),
    .VecOpM     (VecOpM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .vWriteDataM(vWriteDataM),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .ReadDataM  (ReadDataM),
    .vReadDataM (vReadDataM),
    .StallM     (StallM),
    .vDoneM     (vDoneM)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, read-before-write, 1-cycle read latency
  logic [MW-1:0] ram [int];
  always @(posedge clk) begin
    mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : '0;
    if (mem_we) ram[int'(mem_addr)] = mem_wdata;
  end

  // Reference model: memory contents and the last completed vector load
  logic [MW-1:0] ref_mem [int];
  logic [VW-1:0] model_vread = '0;

  function automatic logic [MW-1:0] ref_rd(input logic [N-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  typedef struct {
    int            kind;
    logic [N-1:0]  addr;
    logic [VW-1:0] data;
    int            lat;
  } exp_t;
  exp_t sbq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_exp(input int k, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: -1, addr: '0, data: '0, lat: 0};
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d expected no event", k);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k) begin
        n_fail++;
        $display("FAIL event_order: got kind %0d expected kind %0d", k, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result
  int   cyc = 0, acc_cyc = 0, stall_cnt = 0;
  logic prev_stall = 1'b0, prev_sload = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      prev_sload = 1'b0;
      stall_cnt  = 0;
    end else begin
      if (prev_sload) begin
        pop_exp(K_RD, e, ok);
        if (ok) chk("scalar_load_data", VW'(ReadDataM), e.data);
      end
      if (mem_we) begin
        pop_exp(K_WR, e, ok);
        if (ok) begin
          chk("write_addr", VW'(mem_addr), VW'(e.addr));
          chk("write_data", VW'(mem_wdata), e.data);
        end
      end
      if (StallM) begin
        if (!prev_stall) begin
          acc_cyc   = cyc;
          stall_cnt = 0;
        end
        stall_cnt++;
      end
      if (vDoneM) begin
        pop_exp(K_VD, e, ok);
        if (ok) begin
          chk("vdone_latency", VW'(cyc - acc_cyc), VW'(e.lat));
          chk("stall_cycles", VW'(stall_cnt), VW'(e.lat));
          chk("vread_data", vReadDataM, e.data);
        end
      end
      prev_stall = StallM;
      prev_sload = !StallM && !vDoneM && !VecOpM && MemtoRegM && !MemWriteM;
    end
  end

  task automatic rand_vec(output logic [VW-1:0] v);
    for (int i = 0; i < int'(NB); i++) v[MW*i +: MW] = $urandom;
  endtask

  task automatic scramble();
    logic [VW-1:0] v;
    rand_vec(v);
    MemWriteM   = 1'($urandom);
    MemtoRegM   = 1'($urandom);
    VecOpM      = 1'($urandom);
    ALUResultM  = N'($urandom);
    WriteDataM  = N'($urandom);
    vWriteDataM = v;
  endtask

  task automatic set_idle();
    MemWriteM  = 1'b0;
    MemtoRegM  = 1'b0;
    VecOpM     = 1'b0;
    ALUResultM = N'($urandom);
    WriteDataM = N'($urandom);
  endtask

  task automatic sc_store(input logic [N-1:0] a, input logic [N-1:0] d);
    MemWriteM  = 1'b1;
    MemtoRegM  = 1'b0;
    VecOpM     = 1'b0;
    ALUResultM = a;
    WriteDataM = d;
    ref_mem[int'(a)] = MW'(d);
    sbq.push_back('{kind: K_WR, addr: a, data: VW'(d), lat: 0});
    @(negedge clk);
    chk("scalar_store_nostall", VW'(StallM), '0);
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic sc_load(input logic [N-1:0] a);
    logic [MW-1:0] w;
    MemWriteM  = 1'b0;
    MemtoRegM  = 1'b1;
    VecOpM     = 1'b0;
    ALUResultM = a;
    w = ref_rd(a);
    sbq.push_back('{kind: K_RD, addr: a, data: VW'(w[N-1:0]), lat: 0});
    @(negedge clk);
    chk("scalar_load_nostall", VW'(StallM), '0);
    @(posedge clk); #1;
    set_idle();
  endtask

  // Runs the cycles after an accept; rst_at >= 0 asserts reset in that cycle
  task automatic vec_run(input int rst_at);
    bit done = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c < 40 && !done; c++) begin
      if (c == rst_at) begin
        rst = 1'b1;
        set_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_stall", VW'(StallM), '0);
        chk("post_reset_we", VW'(mem_we), '0);
        chk("post_reset_done", VW'(vDoneM), '0);
        chk("post_reset_vread", vReadDataM, '0);
        chk("post_reset_pending", VW'(sbq.size()), '0);
        @(posedge clk); #1;
        return;
      end
      scramble();
      @(negedge clk);
      done = vDoneM;
      @(posedge clk); #1;
    end
    set_idle();
    if (!done) chk("vdone_timeout", 1, 0);
  endtask

  task automatic vec_store(input logic [N-1:0] base, input logic [VW-1:0] v, input int rst_at);
    int nbeats;
    MemWriteM   = 1'b1;
    MemtoRegM   = 1'($urandom);
    VecOpM      = 1'b1;
    ALUResultM  = base;
    vWriteDataM = v;
    nbeats = (rst_at < 0) ? int'(NB) : rst_at - 1;
    for (int i = 0; i < nbeats; i++) begin
      logic [N-1:0] a;
      a = base + N'(i);
      ref_mem[int'(a)] = v[MW*i +: MW];
      sbq.push_back('{kind: K_WR, addr: a, data: VW'(v[MW*i +: MW]), lat: 0});
    end
    if (rst_at < 0) sbq.push_back('{kind: K_VD, addr: base, data: model_vread, lat: int'(NB) + 1});
    else model_vread = '0;
    @(negedge clk);
    chk("vec_accept_stall", VW'(StallM), VW'(1));
    chk("vec_accept_we", VW'(mem_we), '0);
    vec_run(rst_at);
  endtask

  task automatic vec_load(input logic [N-1:0] base);
    logic [VW-1:0] v;
    MemWriteM  = 1'b0;
    MemtoRegM  = 1'b1;
    VecOpM     = 1'b1;
    ALUResultM = base;
    for (int i = 0; i < int'(NB); i++) v[MW*i +: MW] = ref_rd(base + N'(i));
    model_vread = v;
    sbq.push_back('{kind: K_VD, addr: base, data: v, lat: int'(NB) + 2});
    @(negedge clk);
    chk("vec_accept_stall", VW'(StallM), VW'(1));
    vec_run(-1);
  endtask

  function automatic logic [N-1:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return N'($urandom_range(0, 63));
      1:       return N'(24'hFFFFF0 + $urandom_range(0, 15));
      default: return N'(24'h000100 + $urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    logic [VW-1:0] v;
    rst = 1'b1;
    vWriteDataM = '0;
    set_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", VW'(StallM), '0);
    chk("reset_vdone", VW'(vDoneM), '0);
    chk("reset_we", VW'(mem_we), '0);
    chk("reset_vread", vReadDataM, '0);
    @(posedge clk); #1;

    sc_store(24'h000010, 24'hABCDEF);
    sc_load(24'h000010);

    for (int i = 0; i < int'(NB); i++) v[MW*i +: MW] = 32'h1111_1111 * i;
    vec_store(24'h000020, v, -1);
    vec_load(24'h000020);

    rand_vec(v);
    vec_store(24'hFFFFFE, v, -1);
    vec_load(24'hFFFFFE);
    sc_load(24'h000003);

    rand_vec(v);
    vec_store(24'h000040, v, 4);
    repeat (3) begin
      @(posedge clk); #1;
    end

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: sc_store(rand_addr(), N'($urandom));
        1: sc_load(rand_addr());
        2: begin rand_vec(v); vec_store(rand_addr(), v, -1); end
        3: vec_load(rand_addr());
        default: begin @(posedge clk); #1; end
      endcase
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", VW'(sbq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
